// File: rtl/skeleton_system.sv
// skeleton_system: single-cycle 32-bit processor with instruction ROM,
// 32x32 register file, ALU and data RAM; one instruction per clock.
module skeleton_system #(
   parameter string IMEM_FILE = "imem.mem",
   parameter int    MEM_DEPTH = 4096
) (
   input logic clock,
   input logic reset
);

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] OP_BEX  = 5'b10110;

   localparam logic [4:0] FN_ADD = 5'b00000;
   localparam logic [4:0] FN_SUB = 5'b00001;
   localparam logic [4:0] FN_AND = 5'b00010;
   localparam logic [4:0] FN_OR  = 5'b00011;
   localparam logic [4:0] FN_SLL = 5'b00100;
   localparam logic [4:0] FN_SRA = 5'b00101;

   localparam logic [4:0] R_STATUS = 5'd30;
   localparam logic [4:0] R_LINK   = 5'd31;

   logic [31:0] imem   [MEM_DEPTH];
   logic [31:0] dmem_q [MEM_DEPTH];
   logic [31:0] regs_q [32];
   logic [11:0] pc_q;
   logic [11:0] pc_d;

   logic [31:0] inst;
   logic [4:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  shamt;
   logic [4:0]  aluop;
   logic [31:0] n_ext;
   logic [11:0] target;
   logic        unused_bits;

   assign inst        = imem[pc_q];
   assign opcode      = inst[31:27];
   assign rd          = inst[26:22];
   assign rs          = inst[21:17];
   assign rt          = inst[16:12];
   assign shamt       = inst[11:7];
   assign aluop       = inst[6:2];
   assign n_ext       = {{15{inst[16]}}, inst[16:0]};
   assign target      = inst[11:0];
   assign unused_bits = ^inst[1:0];

   // r0 is forced to zero on read so storage contents never matter
   logic [31:0] rd_val;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] st_val;

   assign rd_val = (rd == 5'd0) ? 32'd0 : regs_q[rd];
   assign rs_val = (rs == 5'd0) ? 32'd0 : regs_q[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : regs_q[rt];
   assign st_val = regs_q[R_STATUS];

   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] sum_i;
   logic        add_ovf;
   logic        sub_ovf;
   logic        addi_ovf;
   logic [11:0] mem_addr;
   logic [11:0] pc_inc;
   logic [11:0] pc_br;

   assign sum      = rs_val + rt_val;
   assign diff     = rs_val - rt_val;
   assign sum_i    = rs_val + n_ext;
   assign add_ovf  = (rs_val[31] == rt_val[31]) && (sum[31] != rs_val[31]);
   assign sub_ovf  = (rs_val[31] != rt_val[31]) && (diff[31] != rs_val[31]);
   assign addi_ovf = (rs_val[31] == n_ext[31]) && (sum_i[31] != rs_val[31]);
   assign mem_addr = sum_i[11:0];
   assign pc_inc   = pc_q + 12'd1;
   assign pc_br    = pc_inc + n_ext[11:0];

   logic        reg_we_d;
   logic [4:0]  reg_wa_d;
   logic [31:0] reg_wd_d;
   logic        st_we_d;
   logic [31:0] st_wd_d;
   logic        dm_we_d;

   always_comb begin
      pc_d     = pc_inc;
      reg_we_d = 1'b0;
      reg_wa_d = rd;
      reg_wd_d = 32'd0;
      st_we_d  = 1'b0;
      st_wd_d  = 32'd0;
      dm_we_d  = 1'b0;
      case (opcode)
         OP_ALU: begin
            reg_we_d = 1'b1;
            case (aluop)
               FN_ADD: begin
                  reg_wd_d = sum;
                  st_we_d  = add_ovf;
                  st_wd_d  = 32'd1;
               end
               FN_SUB: begin
                  reg_wd_d = diff;
                  st_we_d  = sub_ovf;
                  st_wd_d  = 32'd3;
               end
               FN_AND:  reg_wd_d = rs_val & rt_val;
               FN_OR:   reg_wd_d = rs_val | rt_val;
               FN_SLL:  reg_wd_d = rs_val << shamt;
               FN_SRA:  reg_wd_d = $signed(rs_val) >>> shamt;
               default: reg_we_d = 1'b0;
            endcase
         end
         OP_ADDI: begin
            reg_we_d = 1'b1;
            reg_wd_d = sum_i;
            st_we_d  = addi_ovf;
            st_wd_d  = 32'd2;
         end
         OP_SW:  dm_we_d = 1'b1;
         OP_LW: begin
            reg_we_d = 1'b1;
            reg_wd_d = dmem_q[mem_addr];
         end
         OP_J:   pc_d = target;
         OP_BNE: begin
            if (rd_val != rs_val) pc_d = pc_br;
         end
         OP_BLT: begin
            if ($signed(rd_val) < $signed(rs_val)) pc_d = pc_br;
         end
         OP_JAL: begin
            reg_we_d = 1'b1;
            reg_wa_d = R_LINK;
            reg_wd_d = {20'd0, pc_inc};
            pc_d     = target;
         end
         OP_JR:  pc_d = rd_val[11:0];
         OP_BEX: begin
            if (st_val != 32'd0) pc_d = target;
         end
         OP_SETX: begin
            st_we_d = 1'b1;
            st_wd_d = {5'd0, inst[26:0]};
         end
         default: ;
      endcase
   end

   // status port is applied last so it overrides a same-cycle rd==r30 write
   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_q <= 12'd0;
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      end else begin
         pc_q <= pc_d;
         if (reg_we_d && reg_wa_d != 5'd0) regs_q[reg_wa_d] <= reg_wd_d;
         if (st_we_d) regs_q[R_STATUS] <= st_wd_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset && dm_we_d) dmem_q[mem_addr] <= rd_val;
   end

endmodule

// File: tb/tb_skeleton_system.sv
// tb_skeleton_system: directed programs plus random programs checked
// against an instruction-level reference model.
module tb_skeleton_system;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   skeleton_system #(
      .IMEM_FILE(""),
      .MEM_DEPTH(4096)
   ) dut (
      .clock(clock),
      .reset(reset)
   );

   always #5 clock = ~clock;

   logic [31:0] m_i [4096];
   logic [31:0] m_d [4096];
   logic [31:0] m_r [32];
   int          m_pc;

   function automatic longint sv(input logic [31:0] x);
      return longint'($signed(x));
   endfunction

   function automatic logic [31:0] rtype(input int fn, input int rd,
                                         input int rs, input int rt,
                                         input int sh);
      return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(fn), 2'b00};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rd,
                                         input int rs, input int imm);
      logic [31:0] v;
      v = imm;
      return {5'(op), 5'(rd), 5'(rs), v[16:0]};
   endfunction

   function automatic logic [31:0] jtype(input int op, input int t);
      logic [31:0] v;
      v = t;
      return {5'(op), v[26:0]};
   endfunction

   task automatic m_reset();
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
   endtask

   // Architectural semantics: overflow means the exact result does not
   // fit in 32 signed bits; addresses and PCs reduce modulo 4096.
   task automatic m_step();
      logic [31:0] ins, a, b, d, wval;
      int          op, rd, rs, rt, sh, fn, nxt, wdst, addr;
      longint      n, c, stat;
      ins  = m_i[m_pc];
      op   = int'(ins[31:27]);
      rd   = int'(ins[26:22]);
      rs   = int'(ins[21:17]);
      rt   = int'(ins[16:12]);
      sh   = int'(ins[11:7]);
      fn   = int'(ins[6:2]);
      n    = longint'($signed(ins[16:0]));
      a    = m_r[rs];
      b    = m_r[rt];
      d    = m_r[rd];
      nxt  = (m_pc + 1) % 4096;
      wdst = 0;
      wval = 32'd0;
      stat = -1;
      addr = int'((sv(a) + n) & 64'hFFF);
      case (op)
         0: begin
            wdst = rd;
            case (fn)
               0: begin
                  c = sv(a) + sv(b);
                  wval = c[31:0];
                  if (c != sv(wval)) stat = 1;
               end
               1: begin
                  c = sv(a) - sv(b);
                  wval = c[31:0];
                  if (c != sv(wval)) stat = 3;
               end
               2: wval = a & b;
               3: wval = a | b;
               4: wval = a << sh;
               5: wval = $signed(a) >>> sh;
               default: wdst = 0;
            endcase
         end
         5: begin
            c = sv(a) + n;
            wdst = rd;
            wval = c[31:0];
            if (c != sv(wval)) stat = 2;
         end
         7: m_d[addr] = d;
         8: begin
            wdst = rd;
            wval = m_d[addr];
         end
         1: nxt = int'(ins[11:0]);
         2: if (d != a) nxt = int'((m_pc + 1 + n) & 64'hFFF);
         6: if (sv(d) < sv(a)) nxt = int'((m_pc + 1 + n) & 64'hFFF);
         3: begin
            wdst = 31;
            wval = 32'(nxt);
            nxt = int'(ins[11:0]);
         end
         4: nxt = int'(d[11:0]);
         22: if (m_r[30] != 32'd0) nxt = int'(ins[11:0]);
         21: stat = longint'(ins[26:0]);
         default: ;
      endcase
      if (wdst != 0) m_r[wdst] = wval;
      if (stat >= 0) m_r[30] = stat[31:0];
      m_pc = nxt;
   endtask

   task automatic cycle(input int n);
      logic r;
      repeat (n) begin
         @(posedge clock);
         r = reset;
         @(negedge clock);
         if (!r) m_reset();
         else m_step();
      end
   endtask

   task automatic load(input logic [31:0] prog [$], input logic [31:0] fill);
      logic [31:0] w;
      for (int i = 0; i < 4096; i++) begin
         w = (i < prog.size()) ? prog[i] : fill;
         dut.imem[i] = w;
         m_i[i] = w;
      end
   endtask

   task automatic put(input int addr, input logic [31:0] w);
      dut.imem[addr] = w;
      m_i[addr] = w;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      cycle(n);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] p [$];
      p = {itype(5, 1, 0, 1), itype(5, 2, 0, 2)};
      load(p, 32'd0);
      do_reset(2);
      checks++;
      if (dut.pc_q !== 12'd0) begin
         errors++;
         $display("FAIL reset_pc got %0d want 0", dut.pc_q);
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (dut.regs_q[i] !== 32'd0) begin
            errors++;
            $display("FAIL reset_r%0d got %h want 0", i, dut.regs_q[i]);
         end
      end
   endtask

   task automatic test_alu();
      logic [31:0] p [$];
      int          rr [4] = '{1, 2, 3, 4};
      logic [31:0] ev [4] = '{32'd5, 32'd3, 32'd8, 32'd2};
      p = {itype(5, 1, 0, 5), itype(5, 2, 0, 3),
           rtype(0, 3, 1, 2, 0), rtype(1, 4, 1, 2, 0)};
      load(p, 32'd0);
      do_reset(2);
      cycle(4);
      foreach (rr[k]) begin
         checks++;
         if (dut.regs_q[rr[k]] !== ev[k]) begin
            errors++;
            $display("FAIL alu_r%0d got %h want %h", rr[k],
                     dut.regs_q[rr[k]], ev[k]);
         end
      end
      checks++;
      if (dut.pc_q !== 12'd4) begin
         errors++;
         $display("FAIL alu_pc got %0d want 4", dut.pc_q);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] p [$];
      int          step [4] = '{4, 2, 1, 2};
      int          rr [4] = '{3, 5, 30, 7};
      logic [31:0] ev [4] = '{32'h0, 32'h80000001, 32'd2, 32'h7fffffff};
      logic [31:0] es [4] = '{32'd1, 32'd1, 32'd2, 32'd3};
      p = {itype(5, 1, 0, 1), rtype(4, 1, 1, 0, 31),
           rtype(1, 2, 1, 0, 0), rtype(0, 3, 1, 1, 0),
           itype(5, 4, 0, -1), rtype(1, 5, 1, 4, 0),
           itype(5, 30, 1, -1), itype(5, 6, 0, 1),
           rtype(1, 7, 1, 6, 0)};
      load(p, 32'd0);
      do_reset(1);
      foreach (step[k]) begin
         cycle(step[k]);
         checks++;
         if (dut.regs_q[rr[k]] !== ev[k]) begin
            errors++;
            $display("FAIL ovf_r%0d got %h want %h", rr[k],
                     dut.regs_q[rr[k]], ev[k]);
         end
         checks++;
         if (dut.regs_q[30] !== es[k]) begin
            errors++;
            $display("FAIL ovf_status%0d got %h want %h", k,
                     dut.regs_q[30], es[k]);
         end
      end
      checks++;
      if (dut.regs_q[2] !== 32'h80000000) begin
         errors++;
         $display("FAIL ovf_r2 got %h want 80000000", dut.regs_q[2]);
      end
   endtask

   task automatic test_memory();
      logic [31:0] p [$];
      p = {itype(5, 1, 0, 77), itype(7, 1, 0, 10), itype(8, 2, 0, 10),
           itype(5, 3, 0, 4100), itype(7, 1, 3, 0), itype(8, 4, 0, 4)};
      load(p, 32'd0);
      do_reset(1);
      cycle(3);
      checks++;
      if (dut.dmem_q[10] !== 32'd77) begin
         errors++;
         $display("FAIL mem_d10 got %h want %h", dut.dmem_q[10], 32'd77);
      end
      checks++;
      if (dut.regs_q[2] !== 32'd77) begin
         errors++;
         $display("FAIL mem_lw got %h want %h", dut.regs_q[2], 32'd77);
      end
      cycle(3);
      checks++;
      if (dut.dmem_q[4] !== 32'd77) begin
         errors++;
         $display("FAIL mem_wrap got %h want %h", dut.dmem_q[4], 32'd77);
      end
      checks++;
      if (dut.regs_q[4] !== 32'd77) begin
         errors++;
         $display("FAIL mem_lw_wrap got %h want %h", dut.regs_q[4], 32'd77);
      end
   endtask

   task automatic test_branches();
      logic [31:0] p [$];
      int          step [3] = '{4, 1, 1};
      int          epc [3] = '{4, 15, 4094};
      p = {itype(5, 1, 0, 1), itype(2, 1, 0, 2), itype(5, 2, 0, 9),
           itype(5, 3, 0, 9), itype(5, 4, 0, 4), itype(6, 0, 1, -5)};
      load(p, 32'd0);
      do_reset(1);
      cycle(3);
      checks++;
      if (dut.pc_q !== 12'd5 || dut.regs_q[4] !== 32'd4) begin
         errors++;
         $display("FAIL br_bne got pc=%0d r4=%h want pc=5 r4=4",
                  dut.pc_q, dut.regs_q[4]);
      end
      checks++;
      if (dut.regs_q[2] !== 32'd0 || dut.regs_q[3] !== 32'd0) begin
         errors++;
         $display("FAIL br_skip got r2=%h r3=%h want 0 0",
                  dut.regs_q[2], dut.regs_q[3]);
      end
      cycle(1);
      checks++;
      if (dut.pc_q !== 12'd1) begin
         errors++;
         $display("FAIL br_blt got pc=%0d want 1", dut.pc_q);
      end
      p = {itype(5, 1, 0, 1), itype(5, 5, 0, -1), itype(6, 1, 5, 5),
           itype(2, 0, 0, 5), itype(6, 5, 1, 10)};
      load(p, 32'd0);
      put(15, itype(2, 1, 0, -18));
      do_reset(1);
      foreach (step[k]) begin
         cycle(step[k]);
         checks++;
         if (dut.pc_q !== 12'(epc[k])) begin
            errors++;
            $display("FAIL br_pc%0d got %0d want %0d", k, dut.pc_q, epc[k]);
         end
      end
   endtask

   task automatic test_jumps();
      logic [31:0] p [$];
      int          step [8] = '{5, 1, 1, 1, 1, 1, 1, 2};
      int          epc [8] = '{5, 20, 6, 7, 40, 4095, 0, 100};
      p = {};
      load(p, 32'd0);
      put(1, jtype(22, 100));
      put(5, jtype(3, 20));
      put(20, itype(4, 31, 0, 0));
      put(6, jtype(21, 7));
      put(7, jtype(22, 40));
      put(40, jtype(1, 4095));
      put(4095, itype(5, 8, 0, 1));
      do_reset(1);
      foreach (step[k]) begin
         cycle(step[k]);
         checks++;
         if (dut.pc_q !== 12'(epc[k])) begin
            errors++;
            $display("FAIL jmp_pc%0d got %0d want %0d", k, dut.pc_q, epc[k]);
         end
      end
      checks++;
      if (dut.regs_q[31] !== 32'd6 || dut.regs_q[30] !== 32'd7) begin
         errors++;
         $display("FAIL jmp_regs got r31=%h r30=%h want 6 7",
                  dut.regs_q[31], dut.regs_q[30]);
      end
      checks++;
      if (dut.regs_q[8] !== 32'd1) begin
         errors++;
         $display("FAIL jmp_wrap got r8=%h want 1", dut.regs_q[8]);
      end
   endtask

   task automatic test_r0_and_reset();
      logic [31:0] p [$];
      p = {itype(5, 0, 0, 5), itype(5, 1, 0, 55), itype(7, 1, 0, 301),
           itype(5, 2, 1, 1)};
      load(p, 32'd0);
      do_reset(2);
      cycle(2);
      checks++;
      if (dut.regs_q[0] !== 32'd0 || dut.regs_q[1] !== 32'd55) begin
         errors++;
         $display("FAIL r0_write got r0=%h r1=%h want 0 37",
                  dut.regs_q[0], dut.regs_q[1]);
      end
      do_reset(1);
      checks++;
      if (dut.pc_q !== 12'd0) begin
         errors++;
         $display("FAIL midreset_pc got %0d want 0", dut.pc_q);
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (dut.regs_q[i] !== 32'd0) begin
            errors++;
            $display("FAIL midreset_r%0d got %h want 0", i, dut.regs_q[i]);
         end
      end
      checks++;
      if (dut.dmem_q[301] === 32'd55) begin
         errors++;
         $display("FAIL midreset_nowrite got %h want untouched",
                  dut.dmem_q[301]);
      end
      cycle(3);
      checks++;
      if (dut.pc_q !== 12'd3 || dut.dmem_q[301] !== 32'd55) begin
         errors++;
         $display("FAIL restart got pc=%0d d301=%h want 3 37",
                  dut.pc_q, dut.dmem_q[301]);
      end
   endtask

   function automatic int rreg();
      int pool [8] = '{0, 1, 2, 3, 4, 5, 30, 31};
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
      return pool[$urandom_range(0, 7)];
   endfunction

   function automatic logic [31:0] rand_ins();
      int o;
      case ($urandom_range(0, 12))
         0, 12: return rtype($urandom_range(0, 7), rreg(), rreg(), rreg(),
                             $urandom_range(0, 31));
         1: return itype(5, rreg(), rreg(), int'($urandom_range(0, 131071)));
         2: return itype(7, rreg(), 0, 100 + int'($urandom_range(0, 7)));
         3: return itype(8, rreg(), 0, 100 + int'($urandom_range(0, 7)));
         4: return jtype(1, $urandom_range(8, 63));
         5: return itype(2, rreg(), rreg(), int'($urandom_range(0, 12)) - 6);
         6: return itype(6, rreg(), rreg(), int'($urandom_range(0, 12)) - 6);
         7: return jtype(3, $urandom_range(8, 63));
         8: return itype(4, 31, 0, 0);
         9: return jtype(22, $urandom_range(8, 63));
         10: return jtype(21, $urandom_range(0, 3) * 16000000);
         default: begin
            o = $urandom_range(9, 31);
            if (o == 21 || o == 22) o = 9;
            return jtype(o, $urandom);
         end
      endcase
   endfunction

   task automatic test_random();
      logic [31:0] p [$];
      for (int run = 0; run < 3; run++) begin
         p = {};
         for (int k = 0; k < 8; k++) p.push_back(itype(7, 0, 0, 100 + k));
         for (int k = 8; k < 64; k++) p.push_back(rand_ins());
         load(p, jtype(1, 8));
         for (int k = 100; k < 108; k++) m_d[k] = 32'd0;
         do_reset(1);
         for (int c = 0; c < 300; c++) begin
            if (run == 2 && c == 150) reset = 1'b0;
            cycle(1);
            reset = 1'b1;
            checks++;
            if (dut.pc_q !== 12'(m_pc)) begin
               errors++;
               $display("FAIL rnd%0d_pc cyc %0d got %0d want %0d",
                        run, c, dut.pc_q, m_pc);
            end
            for (int i = 0; i < 32; i++) begin
               checks++;
               if (dut.regs_q[i] !== m_r[i]) begin
                  errors++;
                  $display("FAIL rnd%0d_r%0d cyc %0d got %h want %h",
                           run, i, c, dut.regs_q[i], m_r[i]);
               end
            end
         end
         for (int k = 100; k < 108; k++) begin
            checks++;
            if (dut.dmem_q[k] !== m_d[k]) begin
               errors++;
               $display("FAIL rnd%0d_d%0d got %h want %h",
                        run, k, dut.dmem_q[k], m_d[k]);
            end
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_alu();
      test_overflow();
      test_memory();
      test_branches();
      test_jumps();
      test_r0_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
